param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 59 +++++
 tb/tb_param_sync_fifo.sv | 129 ++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with registered read data, occupancy-based status and sticky error flags
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_WIDTH-1:0]    d_in,
  input  logic                     clr_err,
  output logic [DATA_WIDTH-1:0]    d_out,
  output logic                     d_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign empty        = count == '0;
  assign full         = count == CW'(DEPTH);
  assign almost_empty = count <= CW'(AE_LEVEL);
  assign almost_full  = count >= CW'(AF_LEVEL);
  assign wr_ok = rst_n && wr_en && !full;
  assign rd_ok = rst_n && rd_en && !empty;
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= d_in;
  // error flags: a new error on the same edge as clr_err stays set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        d_out  <= mem[rd_ptr];
      end
      d_valid   <= rd_ok;
      count     <= count + CW'(wr_ok) - CW'(rd_ok);
      overflow  <= (wr_en && full) || (overflow && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
  end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: queue-model scoreboard bench for param_sync_fifo
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] d_in = '0, d_out;
  logic d_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;
  int total = 0, bad = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] dout_m = '0;
  logic ov_m = 1'b0, un_m = 1'b0, ev = 1'b0, go = 1'b0;

  param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in), .clr_err(clr_err),
    .d_out(d_out), .d_valid(d_valid), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock of stimulus; the model advances with the edge, status is checked 1 time unit later
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c, input logic rn);
    logic fm, em;
    wr_en = w; rd_en = r; d_in = d; clr_err = c; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      mq.delete(); ov_m = 1'b0; un_m = 1'b0; dout_m = '0; ev = 1'b0;
    end else begin
      fm = mq.size() == 16;
      em = mq.size() == 0;
      ev = r && !em;
      if (ev) begin
        dout_m = mq.pop_front();
        exp_q.push_back(dout_m);
      end
      if (w && !fm) mq.push_back(d);
      ov_m = (w && fm) ? 1'b1 : (c ? 1'b0 : ov_m);
      un_m = (r && em) ? 1'b1 : (c ? 1'b0 : un_m);
    end
    #1;
    chk("count", int'(count), mq.size());
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("full", int'(full), int'(mq.size() == 16));
    chk("almost_empty", int'(almost_empty), int'(mq.size() <= 2));
    chk("almost_full", int'(almost_full), int'(mq.size() >= 12));
    chk("overflow", int'(overflow), int'(ov_m));
    chk("underflow", int'(underflow), int'(un_m));
  endtask

  // monitor: pops the expected read data whenever the DUT presents a valid word
  always @(negedge clk) if (go) begin
    chk("d_valid", int'(d_valid), int'(ev));
    chk("d_out_hold", int'(d_out), int'(dout_m));
    if (d_valid) begin
      if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
      else chk("read_data", int'(d_out), int'(exp_q.pop_front()));
    end
  end

  initial begin
    logic w, r;
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    go = 1'b1;
    step(0, 0, 8'h00, 0, 1);
    // fill and drain
    for (int i = 1; i <= 16; i++) step(1, 0, 8'(i), 0, 1);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    // overflow at full, oldest entry survives, then clear
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h30 + i), 0, 1);
    step(1, 0, 8'hAA, 0, 1);
    step(0, 1, 8'h00, 0, 1);
    step(0, 0, 8'h00, 1, 1);
    // set wins over clear on the same edge
    step(1, 0, 8'hAB, 0, 1);
    step(1, 0, 8'hAC, 1, 1);
    step(0, 0, 8'h00, 1, 1);
    // underflow right after reset
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 1, 1);
    // simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i), 0, 1);
    for (int i = 0; i < 10; i++) step(1, 1, 8'(8'h60 + i), 0, 1);
    for (int i = 0; i < 11; i++) step(1, 0, 8'(8'h70 + i), 0, 1);
    step(1, 1, 8'hEE, 0, 1);
    step(0, 0, 8'h00, 1, 1);
    // simultaneous at empty: write wins, read rejected
    for (int i = 0; i < 15; i++) step(0, 1, 8'h00, 0, 1);
    step(1, 1, 8'h99, 0, 1);
    step(0, 0, 8'h00, 1, 1);
    // wrap-around with occupancy kept in 1..16
    for (int i = 0; i < 100; i++) begin
      r = (mq.size() > 1) && ($urandom_range(0, 3) != 0);
      w = mq.size() < 16;
      step(w, r, 8'($urandom), 0, 1);
    end
    // mid-operation reset at count 9
    while (mq.size() > 9) step(0, 1, 8'h00, 0, 1);
    while (mq.size() < 9) step(1, 0, 8'($urandom), 0, 1);
    step(1, 1, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h5C, 0, 1);
    step(0, 1, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    // unconstrained random traffic including errors, clears and resets
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) != 0);
    for (int i = 0; i < 20; i++) step(0, 1, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
